// File: rtl/croc_pkg.sv
// rtl/croc_pkg.sv - SoC-level constants, OBI manager types and block-swap FSM states
package croc_pkg;

    localparam int unsigned NUM_REQ_BLOCKS     = 2;
    localparam int unsigned NUM_SRAM_ADDRESSES = 12;

    localparam logic [31:0] SramBaseAddr           = 32'h1000_0000;
    localparam logic [31:0] SramAddrRange          = 32'h0000_1000;
    // Lower half of the SRAM is reserved; swaps may only touch the upper half
    localparam logic [31:0] FIRST_USABLE_SRAM_ADDR = 32'h1000_0800;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        mgr_obi_a_chan_t a;
        logic            req;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        DONE
    } block_swap_state_e;

endpackage

// File: rtl/block_swap_rr_arb.sv
// rtl/block_swap_rr_arb.sv - round-robin one-hot picker for the block swap requesters
module block_swap_rr_arb #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] valid,
    input  logic              accept,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   grant_idx
);

    logic [IdxW-1:0] ptr_q;
    logic            found;
    int unsigned     cand;

    // Scan from the pointer upwards, wrapping, and take the first valid requester
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/block_swap_ctrl.sv
// rtl/block_swap_ctrl.sv - swaps two equal-sized SRAM blocks over an OBI manager port
// Optional completed-swap counter built when BLOCK_SWAP_CNT_EN is defined.
module block_swap_ctrl
    import croc_pkg::*;
#(
    parameter int unsigned NumReq     = NUM_REQ_BLOCKS,
    parameter int unsigned BlockWords = NUM_SRAM_ADDRESSES,
    parameter type         obi_req_t  = mgr_obi_req_t,
    parameter type         obi_rsp_t  = mgr_obi_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    input  logic [NumReq-1:0][31:0] req_addr_a_i,
    input  logic [NumReq-1:0][31:0] req_addr_b_i,
    output logic [NumReq-1:0]      req_ready_o,
    output logic [NumReq-1:0]      done_o,
    output logic                   err_o,
    output logic                   busy_o,
    output obi_req_t               obi_req_o,
    input  obi_rsp_t               obi_rsp_i,
    output logic [15:0]            swap_cnt_o
);

    localparam int unsigned IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned WordW      = (BlockWords > 1) ? $clog2(BlockWords) : 1;
    localparam logic [32:0] BlockBytes = 33'(BlockWords * 4);
    localparam logic [32:0] SramEnd    = {1'b0, SramBaseAddr} + {1'b0, SramAddrRange};

    block_swap_state_e state_q, state_d;

    logic [IdxW-1:0]   owner_q;
    logic [31:0]       addr_a_q, addr_b_q;
    logic [WordW-1:0]  word_q;
    logic [31:0]       tmp_a_q, tmp_b_q;
    logic              err_q;
    logic              pending_q;

    logic [NumReq-1:0] grant;
    logic [IdxW-1:0]   grant_idx;
    logic              accept;
    logic              in_xfer;
    logic              gnt_ev, rsp_ev, bus_err;
    logic              last_word;
    logic              reject;
    logic              bad_align, bad_low, bad_high, bad_overlap;
    logic [31:0]       addr_diff;
    logic [31:0]       word_off;
    logic              unused_rid;

    assign unused_rid = obi_rsp_i.r.rid;

    block_swap_rr_arb #(
        .NumReq (NumReq)
    ) u_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .valid     (req_valid_i),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept    = (state_q == IDLE) && (|req_valid_i);
    assign in_xfer   = (state_q == RD_A) || (state_q == RD_B) ||
                       (state_q == WR_A) || (state_q == WR_B);
    assign gnt_ev    = obi_req_o.req && obi_rsp_i.gnt;
    // rvalid only counts once the current transaction has been granted, so a
    // response left over from an aborted swap can never advance the FSM
    assign rsp_ev    = in_xfer && pending_q && obi_rsp_i.rvalid;
    assign bus_err   = rsp_ev && obi_rsp_i.r.err;
    assign last_word = (word_q == WordW'(BlockWords - 1));
    assign word_off  = {{(30 - WordW){1'b0}}, word_q, 2'b00};

    assign addr_diff   = (addr_a_q > addr_b_q) ? (addr_a_q - addr_b_q) : (addr_b_q - addr_a_q);
    assign bad_align   = (addr_a_q[1:0] != 2'b00) || (addr_b_q[1:0] != 2'b00);
    assign bad_low     = (addr_a_q < FIRST_USABLE_SRAM_ADDR) || (addr_b_q < FIRST_USABLE_SRAM_ADDR);
    assign bad_high    = (({1'b0, addr_a_q} + BlockBytes) > SramEnd) ||
                         (({1'b0, addr_b_q} + BlockBytes) > SramEnd);
    // Identical blocks are a legal no-op, so they are excluded from the overlap test
    assign bad_overlap = (addr_a_q != addr_b_q) && ({1'b0, addr_diff} < BlockBytes);
    assign reject      = bad_align || bad_low || bad_high || bad_overlap;

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        done_o      = '0;
        err_o       = 1'b0;
        busy_o      = (state_q != IDLE);
        obi_req_o   = '0;

        if (in_xfer) begin
            obi_req_o.req     = !pending_q;
            obi_req_o.a.we    = (state_q == WR_A) || (state_q == WR_B);
            obi_req_o.a.be    = 4'hF;
            obi_req_o.a.aid   = 1'b0;
            obi_req_o.a.addr  = ((state_q == RD_A) || (state_q == WR_A) ? addr_a_q : addr_b_q) + word_off;
            obi_req_o.a.wdata = (state_q == WR_A) ? tmp_b_q :
                                (state_q == WR_B) ? tmp_a_q : 32'h0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_o = grant;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (reject || (addr_a_q == addr_b_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = RD_A;
                end
            end
            RD_A: if (rsp_ev) state_d = bus_err ? DONE : RD_B;
            RD_B: if (rsp_ev) state_d = bus_err ? DONE : WR_A;
            WR_A: if (rsp_ev) state_d = bus_err ? DONE : WR_B;
            WR_B: if (rsp_ev) state_d = (bus_err || last_word) ? DONE : RD_A;
            DONE: begin
                done_o[owner_q] = 1'b1;
                err_o           = err_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            word_q    <= '0;
            tmp_a_q   <= '0;
            tmp_b_q   <= '0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q  <= grant_idx;
                addr_a_q <= req_addr_a_i[grant_idx];
                addr_b_q <= req_addr_b_i[grant_idx];
                err_q    <= 1'b0;
                word_q   <= '0;
            end
            if (state_q == CHECK) begin
                err_q <= reject;
            end
            if (gnt_ev) begin
                pending_q <= 1'b1;
            end else if (rsp_ev) begin
                pending_q <= 1'b0;
            end
            if (bus_err) begin
                err_q <= 1'b1;
            end else if (rsp_ev) begin
                if (state_q == RD_A) tmp_a_q <= obi_rsp_i.r.rdata;
                if (state_q == RD_B) tmp_b_q <= obi_rsp_i.r.rdata;
                if ((state_q == WR_B) && !last_word) word_q <= word_q + 1'b1;
            end
        end
    end

`ifdef BLOCK_SWAP_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_q == DONE) && !err_q && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign swap_cnt_o = cnt_q;
`else
    assign swap_cnt_o = '0;
`endif

endmodule

// File: tb/tb_block_swap_ctrl.sv
// tb/tb_block_swap_ctrl.sv - directed self-checking bench for block_swap_ctrl with a 1-cycle SRAM model
module tb_block_swap_ctrl;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_valid = '0;
    logic [1:0][31:0]     req_addr_a = '0;
    logic [1:0][31:0]     req_addr_b = '0;
    logic [1:0]           req_ready;
    logic [1:0]           done;
    logic                 err;
    logic                 busy;
    croc_pkg::mgr_obi_req_t obi_req;
    croc_pkg::mgr_obi_rsp_t obi_rsp;
    logic [15:0]          swap_cnt;

    logic [31:0] mem [0:1023];
    logic        fill = 1'b0;
    logic [15:0] fill_seed = '0;
    int          inj_idx = -1;
    int          txn_cnt = 0;
    logic        rsp_rvalid = 1'b0;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_rdata = '0;

    int total = 0;
    int bad = 0;
    int lat;
    logic e;
    int pulses;

    always #5 clk = ~clk;

    block_swap_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_addr_a_i (req_addr_a),
        .req_addr_b_i (req_addr_b),
        .req_ready_o  (req_ready),
        .done_o       (done),
        .err_o        (err),
        .busy_o       (busy),
        .obi_req_o    (obi_req),
        .obi_rsp_i    (obi_rsp),
        .swap_cnt_o   (swap_cnt)
    );

    assign obi_rsp.gnt     = 1'b1;
    assign obi_rsp.rvalid  = rsp_rvalid;
    assign obi_rsp.r.rdata = rsp_rdata;
    assign obi_rsp.r.rid   = 1'b0;
    assign obi_rsp.r.err   = rsp_err;

    // SRAM model: grant in the request cycle, response on the next cycle
    always @(posedge clk) begin
        rsp_rvalid <= 1'b0;
        rsp_err    <= 1'b0;
        if (fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= {fill_seed, 16'(i)};
            txn_cnt <= 0;
        end else if (obi_req.req) begin
            rsp_rvalid <= 1'b1;
            txn_cnt    <= txn_cnt + 1;
            if (txn_cnt == inj_idx) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= 32'h0;
            end else if (obi_req.a.we) begin
                mem[obi_req.a.addr[11:2]] <= obi_req.a.wdata;
            end else begin
                rsp_rdata <= mem[obi_req.a.addr[11:2]];
            end
        end
    end

    function automatic logic [31:0] pat(input logic [15:0] seed, input logic [31:0] addr);
        return {seed, 16'((addr - 32'h1000_0000) >> 2)};
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef BLOCK_SWAP_CNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input logic [15:0] seed);
        @(posedge clk);
        #1 fill = 1'b1;
        fill_seed = seed;
        @(posedge clk);
        #1 fill = 1'b0;
    endtask

    task automatic do_swap(input int k, input logic [31:0] a, input logic [31:0] b,
                           output int l, output logic er);
        int w;
        @(posedge clk);
        #1 req_addr_a[k] = a;
        req_addr_b[k] = b;
        req_valid[k] = 1'b1;
        w = 0;
        @(negedge clk);
        while (!req_ready[k] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept", {31'b0, req_ready[k]}, 32'h1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        er = 1'b0;
        for (l = 1; l <= 300; l++) begin
            @(negedge clk);
            if (done[k]) begin
                er = err;
                break;
            end
        end
    endtask

    task automatic chk_block(input logic [31:0] a, input logic [31:0] b,
                             input logic [15:0] seed, input int n);
        int ia, ib;
        ia = int'((a - 32'h1000_0000) >> 2);
        ib = int'((b - 32'h1000_0000) >> 2);
        for (int i = 0; i < 12; i++) begin
            chk("mem_a", mem[ia + i], (i < n) ? pat(seed, b + 32'(4 * i)) : pat(seed, a + 32'(4 * i)));
            chk("mem_b", mem[ib + i], (i < n) ? pat(seed, a + 32'(4 * i)) : pat(seed, b + 32'(4 * i)));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ready", {30'b0, req_ready}, 32'h0);
        chk("rst_done", {30'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_req", {31'b0, obi_req.req}, 32'h0);
        chk("rst_cnt", {16'b0, swap_cnt}, 32'h0);

        // Round-robin: both valid from reset, misaligned so each finishes in 2 cycles
        @(posedge clk);
        #1 req_addr_a[0] = 32'h1000_0802; req_addr_b[0] = 32'h1000_0900;
        req_addr_a[1] = 32'h1000_0A06; req_addr_b[1] = 32'h1000_0C00;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_first", {30'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rr_busy", {30'b0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rr_done0", {30'b0, done}, 32'h1);
        @(negedge clk);
        chk("rr_second", {30'b0, req_ready}, 32'h2);
        @(posedge clk);
        #1 req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("rr_done1", {30'b0, done}, 32'h2);
        @(negedge clk);
        chk("rr_third", {30'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rr_done0b", {30'b0, done}, 32'h1);

        // Full good swap
        fill_mem(16'hA5A5);
        do_swap(0, 32'h1000_0800, 32'h1000_0900, lat, e);
        chk("swap_lat", 32'(lat), 32'd98);
        chk("swap_err", {31'b0, e}, 32'h0);
        chk("swap_txn", 32'(txn_cnt), 32'd48);
        chk_block(32'h1000_0800, 32'h1000_0900, 16'hA5A5, 12);
        chk("cnt1", {16'b0, swap_cnt}, cnt_exp(1));

        // Rejects: below usable, misaligned, overlap, past SRAM end
        fill_mem(16'h1111);
        do_swap(0, 32'h1000_0400, 32'h1000_0900, lat, e);
        chk("low_lat", 32'(lat), 32'd2);
        chk("low_err", {31'b0, e}, 32'h1);
        do_swap(0, 32'h1000_0802, 32'h1000_0900, lat, e);
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_err", {31'b0, e}, 32'h1);
        do_swap(1, 32'h1000_0800, 32'h1000_0808, lat, e);
        chk("ovl_lat", 32'(lat), 32'd2);
        chk("ovl_err", {31'b0, e}, 32'h1);
        do_swap(1, 32'h1000_0FD4, 32'h1000_0800, lat, e);
        chk("end_lat", 32'(lat), 32'd2);
        chk("end_err", {31'b0, e}, 32'h1);
        chk("rej_txn", 32'(txn_cnt), 32'd0);

        // A == B is a successful no-op
        do_swap(0, 32'h1000_0A00, 32'h1000_0A00, lat, e);
        chk("same_lat", 32'(lat), 32'd2);
        chk("same_err", {31'b0, e}, 32'h0);
        chk("same_txn", 32'(txn_cnt), 32'd0);
        chk("cnt2", {16'b0, swap_cnt}, cnt_exp(2));

        // Bus error on RD_B of word 3 (transaction 13)
        fill_mem(16'h2222);
        inj_idx = 13;
        do_swap(0, 32'h1000_0800, 32'h1000_0900, lat, e);
        inj_idx = -1;
        chk("berr_lat", 32'(lat), 32'd30);
        chk("berr_err", {31'b0, e}, 32'h1);
        chk_block(32'h1000_0800, 32'h1000_0900, 16'h2222, 3);

        // Second good swap from requester 1 at the top of the SRAM
        fill_mem(16'h3333);
        do_swap(1, 32'h1000_0FD0, 32'h1000_0C00, lat, e);
        chk("sw2_lat", 32'(lat), 32'd98);
        chk("sw2_err", {31'b0, e}, 32'h0);
        chk_block(32'h1000_0FD0, 32'h1000_0C00, 16'h3333, 12);
        chk("cnt3", {16'b0, swap_cnt}, cnt_exp(3));

        // Reset in WR_A of word 5 (accept + 46)
        fill_mem(16'h4444);
        @(posedge clk);
        #1 req_addr_a[0] = 32'h1000_0800; req_addr_b[0] = 32'h1000_0900;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_acc", {30'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (46) @(negedge clk);
        chk("wra5_req", {31'b0, obi_req.req}, 32'h1);
        chk("wra5_we", {31'b0, obi_req.a.we}, 32'h1);
        chk("wra5_addr", obi_req.a.addr, 32'h1000_0814);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ab_req", {31'b0, obi_req.req}, 32'h0);
        chk("ab_busy", {31'b0, busy}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done != 2'b00) pulses++;
        end
        chk("ab_nodone", 32'(pulses), 32'd0);
        chk("ab_cnt", {16'b0, swap_cnt}, 32'h0);

        fill_mem(16'h5555);
        do_swap(0, 32'h1000_0800, 32'h1000_0900, lat, e);
        chk("post_lat", 32'(lat), 32'd98);
        chk("post_err", {31'b0, e}, 32'h0);
        chk_block(32'h1000_0800, 32'h1000_0900, 16'h5555, 12);
        chk("post_cnt", {16'b0, swap_cnt}, cnt_exp(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_swap_ctrl.md
BLOCK_SWAP_CTRL -- requirements
Module: block_swap_ctrl

Interface
REQ-001 Parameter NumReq, default croc_pkg::NUM_REQ_BLOCKS (2): number of swap requesters.
REQ-002 Parameter BlockWords, default croc_pkg::NUM_SRAM_ADDRESSES (12): 32-bit words per block.
REQ-003 Parameters obi_req_t / obi_rsp_t, defaults croc_pkg::mgr_obi_req_t / mgr_obi_rsp_t: OBI manager port types.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_valid_i  in  NumReq  per-requester swap request.
REQ-007 req_addr_a_i / req_addr_b_i  in  NumReq x 32  byte base addresses of blocks A and B.
REQ-008 req_ready_o  out  NumReq  one-hot accept strobe.
REQ-009 done_o  out  NumReq  one-cycle completion pulse to the owning requester.
REQ-010 err_o  out  1  valid with done_o: 1 = rejected or bus error.
REQ-011 busy_o  out  1  high whenever the FSM is not IDLE.
REQ-012 obi_req_o / obi_rsp_i  out / in  obi_req_t / obi_rsp_t  OBI manager port into the crossbar.
REQ-013 swap_cnt_o  out  16  count of completed swaps (see Configuration).

Function
REQ-014 Swap semantics: for i = 0..BlockWords-1, A[i] and B[i] are exchanged; at most one OBI transaction is outstanding.
REQ-015 FSM states: IDLE, CHECK, RD_A, RD_B, WR_A, WR_B, DONE.
REQ-016 IDLE: any req_valid_i high -> round-robin pick; req_ready_o[k] high for that cycle only; addresses latched; -> CHECK.
REQ-017 Round-robin priority: the pointer starts at 0 and moves to the index after the granted requester.
REQ-018 Requesters hold valid and addresses stable until ready; while busy, every req_ready_o is 0.
REQ-019 CHECK (1 cycle) rejects with no bus traffic when either address is not word-aligned.
REQ-020 CHECK also rejects when either address is below FIRST_USABLE_SRAM_ADDR.
REQ-021 CHECK also rejects when base + BlockWords*4 exceeds SramBaseAddr + SramAddrRange.
REQ-022 CHECK also rejects when |A-B| < BlockWords*4 (overlap).
REQ-023 A CHECK reject goes to DONE with err = 1.
REQ-024 A CHECK pass with A == B goes to DONE with err = 0 and no bus traffic.
REQ-025 Any other CHECK pass goes to RD_A with word index 0.
REQ-026 Each RD/WR state drives req = 1, we, addr = base + 4*i, be = 4'hF, aid = 0, held stable until gnt; req drops after gnt.
REQ-027 After gnt, each RD/WR state waits for rvalid and only then advances.
REQ-028 RD_A captures rdata into tmp_a and RD_B into tmp_b.
REQ-029 WR_A writes tmp_b to A[i]; WR_B writes tmp_a to B[i].
REQ-030 After WR_B: if i < BlockWords-1, increment i and go to RD_A; otherwise go to DONE.
REQ-031 rvalid with err = 1 in any RD/WR state aborts to DONE with err = 1; earlier words stay swapped.
REQ-032 DONE (1 cycle): done_o[owner] = 1, err_o = error flag; -> IDLE.
REQ-033 A new request may be accepted in the cycle after DONE.
REQ-034 Latency with a 1-cycle SRAM (gnt in the request cycle, rvalid on the next cycle): 2 cycles per transaction, 8 per word.
REQ-035 Total latency: 2 + 8*BlockWords cycles from the accept cycle to done_o (98 for defaults).

Reset
REQ-036 On rst_i: FSM = IDLE; RR pointer, word index, tmp_a, tmp_b and error flag = 0; swap_cnt_o = 0.
REQ-037 On rst_i: obi_req_o.req = 0; req_ready_o, done_o, err_o and busy_o = 0.
REQ-038 Reset mid-swap aborts without a done_o pulse; any late rvalid is ignored.

Configuration
REQ-039 Macro BLOCK_SWAP_CNT_EN defined: swap_cnt_o increments once per done_o with err = 0 and saturates at 16'hFFFF.
REQ-040 Macro BLOCK_SWAP_CNT_EN undefined: the counter is not built and swap_cnt_o = 0.

Structure
REQ-041 BlockWords/NumReq defaults, FIRST_USABLE_SRAM_ADDR and the SRAM range constants are taken from croc_pkg; the FSM state enum is declared in croc_pkg as block_swap_state_e.
REQ-042 The round-robin picker is a sub-module, block_swap_rr_arb (NumReq-wide, one-hot grant, pointer update on accept).

Verification
REQ-043 A = 0x1000_0800, B = 0x1000_0900, distinct patterns: done_o[0] at accept+98, err = 0, contents exchanged, exactly 48 transactions observed.
REQ-044 Both requesters valid in the same cycle from reset: req 0 served first, then req 1; with both still valid afterwards, req 0 is served next.
REQ-045 A = 0x1000_0400 (below usable), A = 0x1000_0802 (misaligned) and B = A + 8 (overlap): done_o at accept+2 with err = 1 and no obi req.
REQ-046 rvalid with err = 1 injected on the RD_B of word 3: done_o with err = 1; words 0..2 swapped, words 3..11 unchanged.
REQ-047 rst_i asserted in WR_A of word 5: next cycle req = 0 and busy_o = 0; no done_o pulse; a new swap then completes normally.
REQ-048 With BLOCK_SWAP_CNT_EN: after 3 good swaps and 1 rejected request swap_cnt_o = 3; without it swap_cnt_o = 0.
